evu_counter_bank: RTL

EVU_COUNTER_BANK -- requirements
Module: evu_counter_bank

---
 rtl/evu_counter_bank_pkg.sv | 27 ++
 rtl/evu_cnt_slice.sv | 36 +++
 rtl/evu_counter_bank.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/evu_counter_bank_pkg.sv
// Shared definitions for the event-unit counter bank: register word indices,
// CTRL/ASID_FLT bit positions and the fixed part of the event info word.
package evu_counter_bank_pkg;

    localparam int unsigned NUM_CNT = 8;

    localparam logic [3:0] REG_EVT_CNT0 = 4'd0;
    localparam logic [3:0] REG_PC_CNT0  = 4'd4;
    localparam logic [3:0] REG_CTRL     = 4'd8;
    localparam logic [3:0] REG_ASID_FLT = 4'd9;
    localparam logic [3:0] REG_THRESH   = 4'd10;
    localparam logic [3:0] REG_STATUS   = 4'd11;
    localparam logic [3:0] REG_IRQ_EN   = 4'd12;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_PRIV_LSB   = 4;
    localparam int unsigned CTRL_PRIV_W     = 4;
    localparam int unsigned ASID_FLT_EN_BIT = 31;

    // Upper fields of e_info; the ASID tail is appended per instance since
    // its width is a module parameter.
    typedef struct packed {
        logic [1:0] counter_no;
        logic [1:0] priv;
    } e_hdr_t;

endpackage

// File: rtl/evu_cnt_slice.sv
// One event counter: increment with wrap, threshold compare and
// CPU-write-over-increment priority. Flag outputs are single-cycle set pulses.
module evu_cnt_slice #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_data,
    input  logic [31:0]          thresh,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf_set,
    output logic                 thr_set
);

    logic                 bump;
    logic [CNT_WIDTH-1:0] count_inc;

    // A colliding CPU write discards the increment, so no flags either.
    assign bump      = inc & ~wr_en;
    assign count_inc = count + CNT_WIDTH'(1);
    assign ovf_set   = bump & (&count);
    assign thr_set   = bump & (thresh != '0) & (32'(count_inc) == thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_en) begin
            count <= wr_data;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/evu_counter_bank.sv
// Event counter bank: four mux-line counters and four PC-match counters,
// qualified by enable/privilege/ASID, with overflow/threshold status and IRQ.
module evu_counter_bank
    import evu_counter_bank_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [4:0]            e_id_i,
    input  logic [ASID_WIDTH+3:0] e_info_i,
    input  logic                  cfg_we_i,
    input  logic                  cfg_re_i,
    input  logic [3:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  cfg_rvalid_o,
    output logic                  irq_o
);

    typedef struct packed {
        e_hdr_t                hdr;
        logic [ASID_WIDTH-1:0] asid;
    } e_info_t;

    if (CNT_WIDTH == 0 || CNT_WIDTH > 32) begin : g_bad_width
        $error("evu_counter_bank: CNT_WIDTH must be 1..32");
    end

    logic [4:0]            e_id_q;
    e_info_t               e_info_q;

    logic                  ctrl_en;
    logic [CTRL_PRIV_W-1:0] priv_mask;
    logic                  flt_en;
    logic [ASID_WIDTH-1:0] flt_val;
    logic [31:0]           thresh;
    logic [15:0]           status;
    logic [15:0]           irq_en;

    logic                  qualify;
    logic [NUM_CNT-1:0]    inc;
    logic [NUM_CNT-1:0]    cnt_we;
    logic [NUM_CNT-1:0]    ovf_set;
    logic [NUM_CNT-1:0]    thr_set;
    logic [CNT_WIDTH-1:0]  cnt [NUM_CNT];

    logic [15:0]           status_clr;
    logic [15:0]           status_nxt;
    logic [31:0]           rd_word;

    // S0: unconditional capture of the event strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_id_q   <= '0;
            e_info_q <= '0;
        end else begin
            e_id_q   <= e_id_i;
            e_info_q <= e_info_i;
        end
    end

    // S1: qualification uses the configuration registers as they stand now
    assign qualify = ctrl_en
                   & priv_mask[e_info_q.hdr.priv]
                   & (~flt_en | (e_info_q.asid == flt_val));

    for (genvar g = 0; g < 4; g++) begin : g_inc
        assign inc[g]     = qualify & e_id_q[g];
        assign inc[g + 4] = qualify & e_id_q[4] & (e_info_q.hdr.counter_no == 2'(g));
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_slice
        assign cnt_we[g] = cfg_we_i & (cfg_addr_i == 4'(g));

        evu_cnt_slice #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slice (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .inc     (inc[g]),
            .wr_en   (cnt_we[g]),
            .wr_data (cfg_wdata_i[CNT_WIDTH-1:0]),
            .thresh  (thresh),
            .count   (cnt[g]),
            .ovf_set (ovf_set[g]),
            .thr_set (thr_set[g])
        );
    end

    // Hardware sets take priority over a W1C landing in the same cycle.
    always_comb begin
        status_clr = '0;
        if (cfg_we_i && cfg_addr_i == REG_STATUS) begin
            status_clr = cfg_wdata_i[15:0];
        end
        status_nxt = (status & ~status_clr) | {thr_set, ovf_set};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en   <= 1'b0;
            priv_mask <= '0;
            flt_en    <= 1'b0;
            flt_val   <= '0;
            thresh    <= '0;
            irq_en    <= '0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                REG_CTRL: begin
                    ctrl_en   <= cfg_wdata_i[CTRL_EN_BIT];
                    priv_mask <= cfg_wdata_i[CTRL_PRIV_LSB +: CTRL_PRIV_W];
                end
                REG_ASID_FLT: begin
                    flt_en  <= cfg_wdata_i[ASID_FLT_EN_BIT];
                    flt_val <= cfg_wdata_i[ASID_WIDTH-1:0];
                end
                REG_THRESH: thresh <= cfg_wdata_i;
                REG_IRQ_EN: irq_en <= cfg_wdata_i[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status <= '0;
            irq_o  <= 1'b0;
        end else begin
            status <= status_nxt;
            irq_o  <= |(status & irq_en);
        end
    end

    // Read mux sees pre-write register values.
    always_comb begin
        rd_word = '0;
        if (!cfg_addr_i[3]) begin
            rd_word = 32'(cnt[cfg_addr_i[2:0]]);
        end else begin
            case (cfg_addr_i)
                REG_CTRL: begin
                    rd_word[CTRL_EN_BIT]                      = ctrl_en;
                    rd_word[CTRL_PRIV_LSB +: CTRL_PRIV_W]     = priv_mask;
                end
                REG_ASID_FLT: begin
                    rd_word[ASID_FLT_EN_BIT]  = flt_en;
                    rd_word[ASID_WIDTH-1:0]   = flt_val;
                end
                REG_THRESH: rd_word = thresh;
                REG_STATUS: rd_word = {16'h0000, status};
                REG_IRQ_EN: rd_word = {16'h0000, irq_en};
                default:    rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rdata_o  <= '0;
            cfg_rvalid_o <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_re_i;
            if (cfg_re_i) begin
                cfg_rdata_o <= rd_word;
            end
        end
    end

endmodule
